// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor
//   Bridges a last-level cache that moves one full line per request onto a
//   burst memory that moves BURST_W bits per beat (BEATS = LINE_W/BURST_W).
//   A request is captured in IDLE, a counted read or write burst follows with
//   one beat per cycle in which resp_i is high, and resp_o then pulses once.
//
// Optional build macro: WRAP_BURST_EN
//   Defined   - critical-beat-first: the burst starts at the beat addressed by
//               address_i and wraps around the line; address_o keeps the
//               beat-offset bits.
//   Undefined - bursts always start at beat 0; address_o is line-aligned.
//
// Ports
//   clk, reset_n   clock, synchronous active-low reset
//   line_i         write line from the LLC, captured on write accept
//   line_o         assembled read line (registered), valid with resp_o
//   address_i      request byte address, captured on accept
//   read_i/write_i level request strobes, accepted in IDLE (read has priority)
//   resp_o         one-cycle completion pulse
//   burst_i        read beat data from memory, taken when resp_i is high in RD
//   burst_o        write beat data to memory, valid while write_o is high
//   address_o      captured, aligned address presented to memory
//   read_o/write_o memory strobes, high for the whole RD / WR state
//   resp_i         memory beat handshake, one beat per high cycle
module cacheline_burst_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS      = LINE_W / BURST_W;
    localparam int CNT_W      = $clog2(BEATS);
    localparam int LINE_OFF_W = $clog2(LINE_W / 8);
    localparam int BEAT_OFF_W = $clog2(BURST_W / 8);

`ifdef WRAP_BURST_EN
    localparam int CLR_W = BEAT_OFF_W;
`else
    localparam int CLR_W = LINE_OFF_W;
`endif
    // Clears the address bits below the unit the memory transfers in.
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << CLR_W) - ADDR_W'(1));

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  start_q, start_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [CNT_W-1:0]  start_in;
    logic [CNT_W-1:0]  idx;
    logic              last_beat;

`ifdef WRAP_BURST_EN
    assign start_in = address_i[LINE_OFF_W-1:BEAT_OFF_W];
`else
    assign start_in = '0;
`endif

    // Beat slot within the line; the CNT_W-bit add wraps modulo BEATS.
    assign idx       = start_q + cnt_q;
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        addr_d  = addr_q;
        line_d  = line_q;
        wline_d = wline_q;
        case (state_q)
            S_IDLE: begin
                if (read_i) begin
                    state_d = S_RD;
                    cnt_d   = '0;
                    start_d = start_in;
                    addr_d  = address_i & ADDR_MASK;
                end else if (write_i) begin
                    state_d = S_WR;
                    cnt_d   = '0;
                    start_d = start_in;
                    addr_d  = address_i & ADDR_MASK;
                    wline_d = line_i;
                end
            end
            S_RD: begin
                if (resp_i) begin
                    line_d[int'(idx)*BURST_W +: BURST_W] = burst_i;
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) state_d = S_DONE;
                end
            end
            S_WR: begin
                if (resp_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            start_q <= '0;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    // The captured write line is pure data: only meaningful while in WR,
    // and burst_o is gated to zero outside WR.
    always_ff @(posedge clk) begin
        wline_q <= wline_d;
    end

    assign read_o    = (state_q == S_RD);
    assign write_o   = (state_q == S_WR);
    assign resp_o    = (state_q == S_DONE);
    assign address_o = addr_q;
    assign line_o    = line_q;
    assign burst_o   = write_o ? wline_q[int'(idx)*BURST_W +: BURST_W] : '0;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
module tb_cacheline_burst_adaptor;
    localparam int LW  = 256;
    localparam int BW  = 64;
    localparam int AW  = 32;
    localparam int NB  = LW / BW;
    localparam int LW2 = 512;
    localparam int BW2 = 32;
    localparam int NB2 = LW2 / BW2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [LW-1:0] line_i, line_o;
    logic [AW-1:0] address_i, address_o;
    logic          read_i, write_i, resp_o, read_o, write_o, resp_i;
    logic [BW-1:0] burst_i, burst_o;

    logic [LW2-1:0] line2_i, line2_o;
    logic [AW-1:0]  address2_i, address2_o;
    logic           read2_i, write2_i, resp2_o, read2_o, write2_o, resp2_i;
    logic [BW2-1:0] burst2_i, burst2_o;

    cacheline_burst_adaptor #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i));

    cacheline_burst_adaptor #(.LINE_W(LW2), .BURST_W(BW2), .ADDR_W(AW)) dut16 (
        .clk(clk), .reset_n(reset_n), .line_i(line2_i), .line_o(line2_o),
        .address_i(address2_i), .read_i(read2_i), .write_i(write2_i), .resp_o(resp2_o),
        .burst_i(burst2_i), .burst_o(burst2_o), .address_o(address2_o),
        .read_o(read2_o), .write_o(write2_o), .resp_i(resp2_i));

    typedef struct {
        bit            rd;
        bit            wr;
        bit            hold;     // keep the request level asserted through DONE
        logic [31:0]   addr;
        logic [LW-1:0] data;     // write line, or read beats in transfer order
        logic [15:0]   stall;    // bit i set: resp_i low on strobe cycle i
        int            exp_cyc;  // expected number of strobe cycles
    } vec_t;

    typedef struct {
        logic [LW-1:0] line;
        logic [31:0]   addr;
    } exp_t;

    vec_t          vecs[6];
    exp_t          sbq[$];
    logic [LW-1:0] last_line;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line slot receiving/supplying the k-th transferred beat.
    function automatic int slot(input logic [31:0] a, input int k);
`ifdef WRAP_BURST_EN
        return (int'(a[4:3]) + k) % NB;
`else
        return k % NB;
`endif
    endfunction

    function automatic int slot2(input logic [31:0] a, input int k);
`ifdef WRAP_BURST_EN
        return (int'(a[5:2]) + k) % NB2;
`else
        return k % NB2;
`endif
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef WRAP_BURST_EN
        return a & ~32'h7;
`else
        return a & ~32'h1F;
`endif
    endfunction

    task automatic run(input vec_t v, input string tag);
        exp_t          e;
        logic [LW-1:0] el;
        int            k, cyc;
        bit            done, bad;
        el = last_line;
        if (v.rd)
            for (int i = 0; i < NB; i++) el[slot(v.addr, i)*BW +: BW] = v.data[i*BW +: BW];
        e.line = el;
        e.addr = exp_addr(v.addr);
        sbq.push_back(e);
        last_line = el;

        read_i = v.rd; write_i = v.wr; address_i = v.addr; line_i = v.data;
        @(negedge clk);
        if (!v.hold) begin read_i = 1'b0; write_i = 1'b0; end
        line_i = ~v.data;
        address_i = 32'hFFFF_FFFF;
        k = 0; cyc = 0; done = 1'b0; bad = 1'b0;
        for (int b = 0; b < 64 && !done; b++) begin
            if (resp_o) begin
                done = 1'b1;
                resp_i = 1'b0;
                if (sbq.size() == 0) check({tag, "_sb_empty"}, 0, 1);
                else begin
                    e = sbq.pop_front();
                    check({tag, "_line_o"}, line_o, e.line);
                    check({tag, "_addr_at_resp"}, address_o, e.addr);
                end
                check({tag, "_strobe_cycles"}, cyc, v.exp_cyc);
                @(negedge clk);
                check({tag, "_idle_gap"}, {resp_o, read_o, write_o}, 3'b000);
                read_i = 1'b0; write_i = 1'b0;
            end else begin
                if (read_o || write_o) begin
                    if (read_o != v.rd || write_o == v.rd) bad = 1'b1;
                    if (cyc == 0) check({tag, "_address_o"}, address_o, exp_addr(v.addr));
                    if (!v.rd && k < NB)
                        check({tag, "_burst_o"}, burst_o, v.data[slot(v.addr, k)*BW +: BW]);
                    resp_i  = !v.stall[cyc % 16];
                    burst_i = (k < NB) ? v.data[k*BW +: BW] : '0;
                    if (resp_i) k++;
                    cyc++;
                end else begin
                    resp_i = 1'b0;
                end
                @(negedge clk);
            end
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
        check({tag, "_strobe_kind"}, bad, 0);
    endtask

    initial begin
        logic [LW2-1:0] exp2;
        int             cyc2;
        bit             done2, seen;

        vecs[0] = '{1, 0, 0, 32'h0000_0100,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 16'h0000, 4};
        vecs[1] = '{0, 1, 0, 32'h0000_2040,
                    {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 16'h001C, 7};
        vecs[2] = '{1, 1, 0, 32'h0000_1234,
                    {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                     64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101}, 16'h0000, 4};
        vecs[3] = '{1, 0, 0, 32'h0000_0050,
                    {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                     64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0}, 16'h0005, 6};
        vecs[4] = '{0, 1, 1, 32'h0000_0068,
                    {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF,
                     64'hCAFE_F00D_DEAD_BEEF, 64'h1357_9246_80AC_E135}, 16'h0000, 4};
        vecs[5] = '{1, 0, 1, 32'h0000_007F,
                    {64'h8888_0000_0000_0003, 64'h8888_0000_0000_0002,
                     64'h8888_0000_0000_0001, 64'h8888_0000_0000_0000}, 16'h0008, 5};

        line_i = '0; address_i = '0; read_i = 0; write_i = 0; resp_i = 0; burst_i = '0;
        line2_i = '0; address2_i = '0; read2_i = 0; write2_i = 0; resp2_i = 0; burst2_i = '0;
        last_line = '0;

        // Reset values
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_resp_o", resp_o, 0);
        check("rst_read_o", read_o, 0);
        check("rst_write_o", write_o, 0);
        check("rst_burst_o", burst_o, 0);
        check("rst_address_o", address_o, 0);
        check("rst_line_o", line_o, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) run(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted while beat 2 of a read is on the bus
        read_i = 1'b1; address_i = 32'h0000_0300;
        @(negedge clk);
        read_i = 1'b0; resp_i = 1'b1; burst_i = 64'h7070_7070_7070_7070;
        @(negedge clk);
        burst_i = 64'h7171_7171_7171_7171;
        @(negedge clk);
        check("abort_in_rd", read_o, 1);
        reset_n = 1'b0; burst_i = 64'h7272_7272_7272_7272;
        @(negedge clk);
        check("abort_read_o", read_o, 0);
        check("abort_line_o", line_o, 0);
        check("abort_resp_o", resp_o, 0);
        reset_n = 1'b1; resp_i = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_o || read_o || write_o) seen = 1'b1;
        end
        check("abort_no_resp", seen, 0);
        last_line = '0;
        sbq.delete();

        for (int i = 3; i < 6; i++) run(vecs[i], $sformatf("vec%0d", i));

        // resp_i in IDLE must be ignored
        resp_i = 1'b1; burst_i = '1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_o || read_o || write_o) seen = 1'b1;
        end
        check("idle_resp_ignored", seen, 0);
        check("idle_line_held", line_o, last_line);
        resp_i = 1'b0;

        // 16-beat configuration, resp_i tied high
        exp2 = '0;
        address2_i = 32'h0000_040C; read2_i = 1'b1;
        @(negedge clk);
        read2_i = 1'b0; address2_i = '1;
        cyc2 = 0; done2 = 1'b0;
        for (int b = 0; b < 64 && !done2; b++) begin
            if (resp2_o) done2 = 1'b1;
            else begin
                if (read2_o) begin
                    resp2_i  = 1'b1;
                    burst2_i = 32'hC0DE_0000 + cyc2;
                    exp2[slot2(32'h0000_040C, cyc2)*BW2 +: BW2] = 32'hC0DE_0000 + cyc2;
                    cyc2++;
                end
                @(negedge clk);
            end
        end
        if (!done2) check("b16_timeout", 0, 1);
        check("b16_transfers", cyc2, NB2);
        check("b16_line_o", line2_o, exp2);
`ifdef WRAP_BURST_EN
        check("b16_address_o", address2_o, 32'h0000_040C);
`else
        check("b16_address_o", address2_o, 32'h0000_0400);
`endif
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp2_o || read2_o || write2_o) seen = 1'b1;
        end
        check("b16_no_extra_beat", seen, 0);
        resp2_i = 1'b0;

        check("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
Parametrised bridge between the last-level cache (one full line per request) and burst memory (BURST_W bits per beat, BEATS = LINE_W/BURST_W beats per line).
- Captures the request address and write line on accept, then runs a counted read or write burst, then pulses resp_o for one cycle.
- Sits between the LLC/arbiter and the physical memory model.
- Beat count is tracked per resp_i, not by fixed sequencing.

Parameters:
LINE_W, 256, cache line width in bits; must be an integer multiple of BURST_W.
BURST_W, 64, memory beat width in bits; BEATS = LINE_W/BURST_W must be a power of two, at least 2.
ADDR_W, 32, address width.

Ports:
clk  in  1  clock.
reset_n  in  1  synchronous active-low reset.
line_i  in  LINE_W  write line from LLC; sampled only on write accept.
line_o  out  LINE_W  assembled read line; valid while resp_o=1 after a read; held until the next read's first beat.
address_i  in  ADDR_W  request byte address; sampled on accept.
read_i  in  1  read request, level; accepted in IDLE.
write_i  in  1  write request, level; accepted in IDLE.
resp_o  out  1  one-cycle completion pulse.
burst_i  in  BURST_W  read beat data; valid when resp_i=1 in RD.
burst_o  out  BURST_W  write beat data; valid while write_o=1.
address_o  out  ADDR_W  latched address, low log2(LINE_W/8) bits forced to 0.
read_o  out  1  memory read strobe; held high for the whole RD state.
write_o  out  1  memory write strobe; held high for the whole WR state.
resp_i  in  1  memory beat handshake; one beat transferred per cycle it is high.

Behaviour:
- Decided: reset reset_n, synchronous, active-low; clock clk.
- Reset values: state=IDLE, beat counter=0, resp_o=0, read_o=0, write_o=0, burst_o=0, address_o=0, line_o=0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - read_i=1 → latch address, clear counter, go to RD.
  - else write_i=1 → latch address and line_i, clear counter, go to WR.
  - read_i and write_i both high → read wins; the write is not queued.
- RD:
  - read_o=1.
  - On each cycle with resp_i=1: write burst_i into line slice [cnt*BURST_W +: BURST_W], then cnt++.
  - When cnt=BEATS-1 and resp_i=1 → DONE.
  - resp_i low cycles are stalls: no beat transferred, counter holds.
- WR:
  - write_o=1; burst_o = latched line slice [cnt*BURST_W +: BURST_W].
  - On resp_i=1: cnt++.
  - Last beat accepted → DONE.
- DONE: resp_o=1 for exactly one cycle, then IDLE. A request level-held in DONE is not accepted until IDLE; minimum gap between resp_o pulses is 1 idle cycle.
- Latency with resp_i tied high from the first strobe cycle: accept edge → BEATS cycles of strobe → resp_o in cycle BEATS+1.
- line_o / latched write line:
  - line_o is a register, not combinational from burst_i.
  - Writes never modify line_o.
  - line_i changes after accept do not affect burst_o.
- Counter width is log2(BEATS); it wraps modulo BEATS, and must not overflow into a (BEATS+1)th beat.
- resp_i in IDLE or DONE is ignored.
- reset_n low mid-burst: next edge forces all reset values, aborting the burst; no resp_o is issued for it.

Optional Feature:
Macro WRAP_BURST_EN.
- Defined: critical-beat-first.
  - Start beat = address_i[log2(LINE_W/8)-1 : log2(BURST_W/8)], latched on accept.
  - Beat index = (start + cnt) mod BEATS, for both read placement into line_o and write selection of burst_o.
  - address_o keeps the beat-offset bits and clears only byte-within-beat bits.
  - Termination is still after BEATS transfers.
- Undefined: start beat is always 0 and address_o is line-aligned.

Test Plan:
- Read, LINE_W=256/BURST_W=64, resp_i high 4 cycles, beats 0x11..,0x22..,0x33..,0x44.. → line_o = {0x44..,0x33..,0x22..,0x11..}; resp_o high exactly one cycle, one cycle after the last beat.
- Write, line_i=0xDDDD..CCCC..BBBB..AAAA.., resp_i stalled low 3 cycles mid-burst → burst_o shows AAAA,BBBB,CCCC,DDDD in order; each beat held through the stall; write_o high for 7 cycles total.
- read_i and write_i asserted together with address_i=0x0000_1234 → RD taken; address_o=0x0000_1220; no write strobe ever appears.
- reset_n low during beat 2 of a read → next cycle read_o=0, line_o=0, state IDLE; no resp_o; a fresh read then completes normally.
- WRAP_BURST_EN, address_i=0x0000_0050 (beat 2) → beats land in slices 2,3,0,1; address_o=0x0000_0050.
- Parameter sweep LINE_W=512, BURST_W=32 (16 beats) → 16 transfers, resp_o after the 16th, no counter overflow.
